// File: rtl/dac_waveform_player.sv
// Waveform player: loads AXI-Stream beats into a buffer RAM, then replays them
// on trigger for a programmable number of passes (0 = loop until stopped).
module dac_waveform_player #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 1024,
  parameter int RPT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  output logic [DATA_W-1:0]      m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  input  logic                   cfg_load,
  input  logic                   cfg_arm,
  input  logic                   cfg_stop,
  input  logic [RPT_W-1:0]       cfg_repeat,
  input  logic                   trigger_in,
  output logic [1:0]             state_o,
  output logic [$clog2(DEPTH):0] wave_len,
  output logic                   done,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      ONE     = 1;
  localparam logic [RPT_W-1:0] RPT_ONE = 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, ARMED = 2'd2, PLAY = 2'd3} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid, rd_last, m_last;
  logic [AW:0]       rd_addr;
  logic [RPT_W-1:0]  passes_left, rpt_latched;
  logic              issue_done, stopping;

  logic              s_hs, m_hs, ce_out, ce_rd, trig_go, issue;
  logic              wrap, final_beat, leave_play;
  logic [AW:0]       cur_addr;
  logic [RPT_W-1:0]  cur_passes;

  assign state_o       = state;
  assign s_axis_tready = (state == LOAD);

  // Two-stage read pipeline (RAM data register, output register) with a
  // combinational ready chain so playback never bubbles under backpressure.
  always_comb begin
    s_hs       = s_axis_tvalid && (state == LOAD);
    m_hs       = m_axis_tvalid && m_axis_tready;
    ce_out     = !m_axis_tvalid || m_axis_tready;
    ce_rd      = !rd_valid || ce_out;
    trig_go    = (state == ARMED) && trigger_in && !cfg_stop && !cfg_load;
    cur_addr   = (state == ARMED) ? '0 : rd_addr;
    cur_passes = (state == ARMED) ? rpt_latched : passes_left;
    wrap       = (cur_addr == wave_len - ONE);
    final_beat = wrap && (cur_passes == RPT_ONE);
    issue      = trig_go ||
                 ((state == PLAY) && !issue_done && !stopping && !cfg_stop && ce_rd);
    done       = !rst && (state == PLAY) && !cfg_stop && !stopping && m_hs && m_last;
    leave_play = (state == PLAY) &&
                 ((cfg_stop || stopping) ? ce_out : (m_hs && m_last));
  end

  always_ff @(posedge clk) begin
    if (s_hs && !wave_len[AW]) mem[wave_len[AW-1:0]] <= s_axis_tdata;
    if (issue) rd_data <= mem[cur_addr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wave_len      <= '0;
      overflow      <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_last        <= 1'b0;
      rd_valid      <= 1'b0;
      rd_last       <= 1'b0;
      rd_addr       <= '0;
      passes_left   <= '0;
      rpt_latched   <= '0;
      issue_done    <= 1'b0;
      stopping      <= 1'b0;
    end else begin
      if (issue) begin
        rd_addr     <= wrap ? '0 : cur_addr + ONE;
        passes_left <= (wrap && cur_passes != '0) ? cur_passes - RPT_ONE : cur_passes;
        rd_last     <= final_beat;
        if (final_beat) issue_done <= 1'b1;
      end
      if (ce_rd) rd_valid <= issue;
      if (ce_out) begin
        m_axis_tvalid <= rd_valid;
        m_axis_tdata  <= rd_valid ? rd_data : '0;
        m_last        <= rd_valid && rd_last;
      end

      case (state)
        IDLE: begin
          if (!cfg_stop) begin
            if (cfg_load) begin
              state    <= LOAD;
              wave_len <= '0;
              overflow <= 1'b0;
            end else if (cfg_arm && wave_len != '0) begin
              state       <= ARMED;
              rpt_latched <= cfg_repeat;
            end
          end
        end
        // Beats past the buffer end are still accepted so the source never stalls.
        LOAD: begin
          if (s_hs) begin
            if (!wave_len[AW]) wave_len <= wave_len + ONE;
            else               overflow <= 1'b1;
          end
          if (cfg_stop || (s_hs && s_axis_tlast)) state <= IDLE;
        end
        ARMED: begin
          if (cfg_stop) begin
            state <= IDLE;
          end else if (cfg_load) begin
            state    <= LOAD;
            wave_len <= '0;
            overflow <= 1'b0;
          end else if (trigger_in) begin
            state      <= PLAY;
            issue_done <= final_beat;
            stopping   <= 1'b0;
          end
        end
        PLAY: begin
          if (cfg_stop || stopping) begin
            stopping <= 1'b1;
            rd_valid <= 1'b0;
          end
        end
      endcase

      // A stop drops the prefetched beat but lets the presented one complete.
      if (leave_play) begin
        state         <= IDLE;
        m_axis_tvalid <= 1'b0;
        m_axis_tdata  <= '0;
        m_last        <= 1'b0;
        rd_valid      <= 1'b0;
        rd_last       <= 1'b0;
        rd_addr       <= '0;
        passes_left   <= '0;
        issue_done    <= 1'b0;
        stopping      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dac_waveform_player.sv
// Self-checking bench for dac_waveform_player: control table plus scoreboarded
// playback sequences (repeat, continuous with backpressure, overflow, reset).
module tb_dac_waveform_player;

  localparam int DATA_W = 256;
  localparam int DEPTH  = 16;
  localparam int RPT_W  = 16;
  localparam int AW     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid, m_axis_tready;
  logic              cfg_load, cfg_arm, cfg_stop;
  logic [RPT_W-1:0]  cfg_repeat;
  logic              trigger_in;
  logic [1:0]        state_o;
  logic [AW:0]       wave_len;
  logic              done, overflow;

  dac_waveform_player #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RPT_W(RPT_W)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .cfg_load(cfg_load), .cfg_arm(cfg_arm), .cfg_stop(cfg_stop),
    .cfg_repeat(cfg_repeat), .trigger_in(trigger_in),
    .state_o(state_o), .wave_len(wave_len), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              done;
  } exp_t;

  typedef struct {
    logic       load, arm, stop, trig, sv, sl;
    int         sd;
    logic [1:0] e_state;
    logic [AW:0] e_len;
    logic       e_sready;
    logic       e_tvalid;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[17];
  int   errors = 0;
  int   checks = 0;
  int   s_hs_count = 0;
  logic prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  function automatic vec_t mkv(logic ld, logic ar, logic st, logic tr, logic sv, logic sl,
                               int sd, logic [1:0] es, int el, logic esr, logic etv);
    vec_t v;
    v.load = ld; v.arm = ar; v.stop = st; v.trig = tr; v.sv = sv; v.sl = sl; v.sd = sd;
    v.e_state = es; v.e_len = (AW+1)'(el); v.e_sready = esr; v.e_tvalid = etv;
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] beatVal(int v, bit wide);
    logic [31:0] w;
    w = 32'(v);
    return wide ? {8{w}} : DATA_W'(w);
  endfunction

  task automatic checkOutput(string name, logic [DATA_W-1:0] got, logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (s_axis_tvalid && s_axis_tready) s_hs_count++;
    if (prev_stall) begin
      checkOutput("hold_valid", DATA_W'(m_axis_tvalid), DATA_W'(1));
      checkOutput("hold_data", m_axis_tdata, prev_data);
    end
    if (m_axis_tvalid && m_axis_tready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_beat: got %0h expected no beat", m_axis_tdata);
      end else begin
        e = sb.pop_front();
        if (m_axis_tdata !== e.data || done !== e.done) begin
          errors++;
          $display("[TB] FAIL beat: got data %0h done %0b expected data %0h done %0b",
                   m_axis_tdata, done, e.data, e.done);
        end
      end
    end else begin
      checkOutput("idle_done", DATA_W'(done), '0);
    end
    if (!m_axis_tvalid) checkOutput("zero_data", m_axis_tdata, '0);
    prev_stall = m_axis_tvalid && !m_axis_tready && !rst;
    prev_data  = m_axis_tdata;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(vec_t v);
    cfg_load      = v.load;
    cfg_arm       = v.arm;
    cfg_stop      = v.stop;
    trigger_in    = v.trig;
    s_axis_tvalid = v.sv;
    s_axis_tlast  = v.sl;
    s_axis_tdata  = beatVal(v.sd, 1'b0);
    tick();
  endtask

  task automatic checkState(string tag, logic [1:0] es, int el, logic etv);
    checkOutput({tag, "_state"}, DATA_W'(state_o), DATA_W'(es));
    checkOutput({tag, "_len"}, DATA_W'(wave_len), DATA_W'(el));
    checkOutput({tag, "_tvalid"}, DATA_W'(m_axis_tvalid), DATA_W'(etv));
  endtask

  task automatic loadSeq(int n, int base, bit wide);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = beatVal(base + i, wide);
      s_axis_tlast  = (i == n - 1);
      tick();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
  endtask

  task automatic armWith(int rpt);
    cfg_repeat = RPT_W'(rpt);
    cfg_arm    = 1'b1;
    tick();
    cfg_arm    = 1'b0;
  endtask

  task automatic pushBeat(logic [DATA_W-1:0] d, logic dn);
    exp_t e;
    e.data = d;
    e.done = dn;
    sb.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    exp_t keep;
    rst = 1'b1;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b0;
    cfg_load = 1'b0; cfg_arm = 1'b0; cfg_stop = 1'b0;
    cfg_repeat = '0; trigger_in = 1'b0;
    @(posedge clk);
    #1;
    tick();
    checkState("reset", 2'd0, 0, 1'b0);
    checkOutput("reset_tdata", m_axis_tdata, '0);
    checkOutput("reset_overflow", DATA_W'(overflow), '0);
    checkOutput("reset_sready", DATA_W'(s_axis_tready), '0);
    checkOutput("reset_done", DATA_W'(done), '0);
    rst = 1'b0;

    // Control table: empty-buffer arm, load of 8 beats, command priority, arm.
    vecs[0]  = mkv(0,1,0,0,0,0, 0, 2'd0, 0, 0, 0);
    vecs[1]  = mkv(0,0,0,1,0,0, 0, 2'd0, 0, 0, 0);
    vecs[2]  = mkv(1,0,0,0,0,0, 0, 2'd1, 0, 1, 0);
    vecs[3]  = mkv(0,0,0,0,1,0, 1, 2'd1, 1, 1, 0);
    vecs[4]  = mkv(0,0,0,0,0,0, 0, 2'd1, 1, 1, 0);
    vecs[5]  = mkv(0,0,0,0,1,0, 2, 2'd1, 2, 1, 0);
    vecs[6]  = mkv(0,0,0,0,1,0, 3, 2'd1, 3, 1, 0);
    vecs[7]  = mkv(0,0,0,0,1,0, 4, 2'd1, 4, 1, 0);
    vecs[8]  = mkv(0,0,0,0,1,0, 5, 2'd1, 5, 1, 0);
    vecs[9]  = mkv(0,0,0,0,1,0, 6, 2'd1, 6, 1, 0);
    vecs[10] = mkv(0,0,0,0,1,0, 7, 2'd1, 7, 1, 0);
    vecs[11] = mkv(0,0,0,0,1,1, 8, 2'd0, 8, 0, 0);
    vecs[12] = mkv(0,0,0,0,1,0, 9, 2'd0, 8, 0, 0);
    vecs[13] = mkv(0,0,0,1,0,0, 0, 2'd0, 8, 0, 0);
    vecs[14] = mkv(1,0,1,0,0,0, 0, 2'd0, 8, 0, 0);
    vecs[15] = mkv(0,1,1,0,0,0, 0, 2'd0, 8, 0, 0);
    vecs[16] = mkv(0,1,0,0,0,0, 0, 2'd2, 8, 0, 0);
    cfg_repeat = RPT_W'(2);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i]);
      checkState($sformatf("vec%0d", i), vecs[i].e_state, int'(vecs[i].e_len), vecs[i].e_tvalid);
      checkOutput($sformatf("vec%0d_sready", i), DATA_W'(s_axis_tready), DATA_W'(vecs[i].e_sready));
    end
    cfg_load = 1'b0; cfg_arm = 1'b0; cfg_stop = 1'b0; trigger_in = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0;

    // Two passes of 1..8 with two-cycle trigger latency; a mid-play trigger is ignored.
    for (int k = 0; k < 16; k++) pushBeat(beatVal(k % 8 + 1, 1'b0), k == 15);
    m_axis_tready = 1'b1;
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    checkState("lat1", 2'd3, 8, 1'b0);
    tick();
    checkOutput("lat2_tvalid", DATA_W'(m_axis_tvalid), DATA_W'(1));
    checkOutput("lat2_tdata", m_axis_tdata, beatVal(1, 1'b0));
    for (int k = 0; k < 16; k++) begin
      trigger_in = (k == 5);
      tick();
    end
    trigger_in = 1'b0;
    checkOutput("rpt2_remaining", DATA_W'(sb.size()), '0);
    checkState("rpt2_end", 2'd0, 8, 1'b0);
    tick();
    tick();

    // Continuous play under random backpressure, then stop while stalled.
    armWith(0);
    checkState("cont_arm", 2'd2, 8, 1'b0);
    for (int k = 1; k <= 8; k++) pushBeat(beatVal(k, 1'b0), 1'b0);
    m_axis_tready = 1'b0;
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (sb.size() < 8)
        for (int k = 1; k <= 8; k++) pushBeat(beatVal(k, 1'b0), 1'b0);
      m_axis_tready = 1'($urandom_range(0, 1));
      tick();
    end
    m_axis_tready = 1'b0;
    tick();
    tick();
    keep = sb[0];
    sb.delete();
    sb.push_back(keep);
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    checkState("stop_hold", 2'd3, 8, 1'b1);
    tick();
    m_axis_tready = 1'b1;
    tick();
    checkState("stop_end", 2'd0, 8, 1'b0);
    tick();
    tick();
    checkOutput("stop_remaining", DATA_W'(sb.size()), '0);

    // Overflow: 20 beats into a 16-deep buffer, single pass replays first 16.
    s_hs_count = 0;
    loadSeq(20, 32'h1000, 1'b1);
    checkOutput("ovf_accepted", DATA_W'(s_hs_count), DATA_W'(20));
    checkState("ovf_load", 2'd0, 16, 1'b0);
    checkOutput("ovf_flag", DATA_W'(overflow), DATA_W'(1));
    armWith(1);
    for (int k = 0; k < 16; k++) pushBeat(beatVal(32'h1000 + k, 1'b1), k == 15);
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    checkOutput("ovf_remaining", DATA_W'(sb.size()), '0);
    checkState("ovf_end", 2'd0, 16, 1'b0);

    // Single-beat waveform repeated three times back to back.
    loadSeq(1, 32'hA5, 1'b0);
    checkState("one_load", 2'd0, 1, 1'b0);
    checkOutput("one_ovf_clear", DATA_W'(overflow), '0);
    armWith(3);
    for (int k = 0; k < 3; k++) pushBeat(beatVal(32'hA5, 1'b0), k == 2);
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("one_beat%0d_valid", k), DATA_W'(m_axis_tvalid), DATA_W'(1));
      tick();
    end
    checkOutput("one_remaining", DATA_W'(sb.size()), '0);
    checkState("one_end", 2'd0, 1, 1'b0);
    tick();
    tick();

    // Reset in the middle of a stalled playback; a later arm must be ignored.
    loadSeq(8, 1, 1'b0);
    armWith(0);
    for (int k = 1; k <= 8; k++) pushBeat(beatVal(k, 1'b0), 1'b0);
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    m_axis_tready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    checkState("rst_play", 2'd0, 0, 1'b0);
    checkOutput("rst_play_tdata", m_axis_tdata, '0);
    checkOutput("rst_play_ovf", DATA_W'(overflow), '0);
    checkOutput("rst_play_sready", DATA_W'(s_axis_tready), '0);
    m_axis_tready = 1'b1;
    armWith(1);
    checkState("rst_arm", 2'd0, 0, 1'b0);
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    tick();
    tick();
    checkState("rst_trig", 2'd0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dac_waveform_player.md
DAC_WAVEFORM_PLAYER -- requirements
Module: dac_waveform_player

Interface
REQ-001 SHALL provide parameter DATA_W, default 256, bits per AXI-Stream beat (16 samples x 16 bit).
REQ-002 SHALL provide parameter DEPTH, default 1024, waveform buffer size in beats (power of two, >=4); AW = log2(DEPTH).
REQ-003 SHALL provide parameter RPT_W, default 16, repeat-count width.
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports s_axis_tdata/tvalid/tready/tlast  in/in/out/in  DATA_W/1/1/1  waveform load stream from PS.
REQ-007 SHALL have ports m_axis_tdata/tvalid/tready  out/out/in  DATA_W/1/1  sample stream to RFSoC DAC IP.
REQ-008 SHALL have ports cfg_load, cfg_arm, cfg_stop  input  1 each  single-cycle command pulses.
REQ-009 SHALL have port cfg_repeat  input  RPT_W  passes per trigger; 0 = continuous until stop; sampled on cfg_arm.
REQ-010 SHALL have port trigger_in  input  1  start strobe, acted on while ARMED.
REQ-011 SHALL have ports state_o  output  2,  wave_len  output  AW+1,  done  output  1,  overflow  output  1.

Function
REQ-012 SHALL implement states IDLE(0), LOAD(1), ARMED(2), PLAY(3) on state_o.
REQ-013 IDLE: cfg_load -> LOAD, wave_len cleared to 0, overflow cleared; cfg_arm with wave_len!=0 -> ARMED; cfg_arm with wave_len=0 ignored.
REQ-014 LOAD: s_axis_tready=1; each handshake writes beat at address wave_len while wave_len<DEPTH and increments wave_len; beats beyond DEPTH accepted, discarded, overflow set (sticky).
REQ-015 LOAD: handshake with tlast=1 -> IDLE next cycle; cfg_stop -> IDLE, beats already written retained.
REQ-016 s_axis_tready SHALL be 0 in all states except LOAD.
REQ-017 ARMED: trigger_in=1 -> PLAY, read address 0, pass counter loaded with cfg_repeat latched at arm; cfg_stop -> IDLE; cfg_load -> LOAD.
REQ-018 Trigger latency: trigger sampled high at cycle T -> m_axis_tvalid=1 with beat 0 at T+2 (synchronous RAM read plus output register).
REQ-019 PLAY: with m_axis_tready held high, one beat per cycle, addresses 0..wave_len-1, wrap to 0 with no bubble.
REQ-020 AXI-Stream rule: once m_axis_tvalid=1, tdata and tvalid SHALL hold until tready=1; buffering (prefetch/skid) SHALL sustain full throughput under arbitrary tready.
REQ-021 Pass end: after beat wave_len-1 accepted, counter decrements if non-zero-mode; last accepted beat of final pass -> IDLE, done pulses 1 cycle, m_axis_tvalid=0 next cycle.
REQ-022 cfg_repeat=0 -> loop indefinitely; done never pulses.
REQ-023 cfg_stop in PLAY: current valid beat held until accepted, then IDLE with tvalid=0; no further beats; done not pulsed.
REQ-024 wave_len=1 SHALL replay beat 0 every cycle.
REQ-025 trigger_in outside ARMED ignored; trigger in PLAY does not restart.
REQ-026 Simultaneous pulses priority: cfg_stop > cfg_load > cfg_arm; cfg_load/cfg_arm in PLAY ignored.
REQ-027 m_axis_tdata SHALL be zero whenever m_axis_tvalid=0.

Reset
REQ-028 rst=1 SHALL force next cycle: state IDLE, wave_len=0, overflow=0, done=0, m_axis_tvalid=0, m_axis_tdata=0, s_axis_tready=0, counters 0, from any state including mid-PLAY/mid-LOAD.
REQ-029 Buffer RAM contents SHALL NOT require reset; unloaded contents never reach m_axis because wave_len=0 blocks arm.

Verification
REQ-030 Load 8 beats (0x1..0x8, tlast on 8th), arm cfg_repeat=2, trigger at T, tready=1 -> beats 1..8,1..8 at T+2..T+17, done at final handshake cycle, state IDLE after.
REQ-031 Same load, cfg_repeat=0, random tready 50% -> stream 1..8 repeating in order, no dropped/duplicated beat, tdata stable while stalled; cfg_stop -> ends after current beat.
REQ-032 DEPTH=16 build, load 20 beats -> all 20 accepted, wave_len=16, overflow=1; playback yields first 16 only.
REQ-033 cfg_arm with wave_len=0 and trigger -> state stays IDLE, m_axis_tvalid stays 0; trigger in IDLE ignored.
REQ-034 rst asserted mid-PLAY with tready=0 -> next cycle tvalid=0, wave_len=0, state IDLE; subsequent arm ignored until reload.
REQ-035 wave_len=1 (beat 0xA5), cfg_repeat=3 -> exactly three 0xA5 beats on consecutive cycles, done with third.
